ising_prog_seq: RTL and testbench

// Upstream host-side sequencer for ising_axi: consumes a stream of (i,j,w) edges and drives the ising_axi write port.

---
 rtl/ising_prog_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ising_prog_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_prog_seq.sv
// ============================================================================
//  Module   : ising_prog_seq
//  Purpose  : Host-side programming sequencer for ising_axi. Writes the
//             cutoff/max counters, consumes a stream of (i,j,w) edges and
//             writes each weight symmetrically, issues START, waits a run
//             window, then reads the N phases back and emits a thresholded
//             N-bit spin vector with a one-cycle done pulse.
//  Ports    : clk, axi_rstn (sync, active low)
//             go, cfg_cutoff, cfg_max, cfg_start, run_cycles  - job setup
//             e_valid/e_ready, e_i, e_j, e_w, e_last           - edge stream
//             wready, wr_addr, wdata                           - write port
//             araddr, rdata                                    - read port
//             busy, done, spins, err_idx                       - status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef START_ADDR
`define START_ADDR        32'h0000_0000
`endif
`ifndef CTR_CUTOFF_ADDR
`define CTR_CUTOFF_ADDR   32'h0000_0004
`endif
`ifndef CTR_MAX_ADDR
`define CTR_MAX_ADDR      32'h0000_0008
`endif
`ifndef PHASE_ADDR_BASE
`define PHASE_ADDR_BASE   32'h0001_0000
`endif
`ifndef WEIGHT_ADDR_BASE
`define WEIGHT_ADDR_BASE  32'h0100_0000
`endif

module ising_prog_seq #(
    parameter int N        = 8,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 32,
    parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             axi_rstn,
    input  logic             go,
    input  logic [31:0]      cfg_cutoff,
    input  logic [31:0]      cfg_max,
    input  logic [31:0]      cfg_start,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             e_valid,
    output logic             e_ready,
    input  logic [IDX_W-1:0] e_i,
    input  logic [IDX_W-1:0] e_j,
    input  logic [31:0]      e_w,
    input  logic             e_last,
    output logic             wready,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wdata,
    output logic [31:0]      araddr,
    input  logic [31:0]      rdata,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     spins,
    output logic             err_idx
);

    localparam int               c_k_w    = (N > 1) ? $clog2(N) : 1;
    localparam int               c_lat_w  = $clog2(READ_LAT + 1);
    localparam logic [c_k_w-1:0] c_k_last = c_k_w'(N - 1);
    localparam logic [c_lat_w-1:0] c_lat  = c_lat_w'(READ_LAT);
    localparam logic [31:0]      c_n      = 32'(N);

    // Each write state is the cycle in which its write is on the port.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_W_CUT   = 4'd1,
        S_W_MAX   = 4'd2,
        S_EDGE    = 4'd3,
        S_W_IJ    = 4'd4,
        S_W_JI    = 4'd5,
        S_W_START = 4'd6,
        S_RUN     = 4'd7,
        S_RD      = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t               r_state;
    logic [31:0]          r_cutoff;
    logic [31:0]          r_max;
    logic [31:0]          r_start;
    logic [CNT_W-1:0]     r_run;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_i;
    logic [IDX_W-1:0]     r_j;
    logic [31:0]          r_w;
    logic                 r_last;
    logic [c_k_w-1:0]     r_k;
    logic [c_lat_w-1:0]   r_lat;
    logic [N-1:0]         r_shadow;

    logic                 w_idx_bad;
    logic [c_k_w-1:0]     w_k_next;
    logic [N-1:0]         w_shadow_next;

    function automatic logic [31:0] weight_addr(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
        return `WEIGHT_ADDR_BASE + (32'(row) << 2) + (32'(col) << 13);
    endfunction

    function automatic logic [31:0] phase_addr(input logic [c_k_w-1:0] k);
        return `PHASE_ADDR_BASE + (32'(k) << 2);
    endfunction

    always_comb begin
        w_idx_bad = (32'(e_i) >= c_n) || (32'(e_j) >= c_n);
        w_k_next  = r_k + c_k_w'(1);
        // Shadow with the phase currently on rdata folded in at bit k.
        w_shadow_next      = r_shadow;
        w_shadow_next[r_k] = (rdata >= r_cutoff);
    end

    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            r_state  <= S_IDLE;
            e_ready  <= 1'b0;
            wready   <= 1'b0;
            wr_addr  <= '0;
            wdata    <= '0;
            araddr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spins    <= '0;
            err_idx  <= 1'b0;
            r_cutoff <= '0;
            r_max    <= '0;
            r_start  <= '0;
            r_run    <= '0;
            r_cnt    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_w      <= '0;
            r_last   <= 1'b0;
            r_k      <= '0;
            r_lat    <= '0;
            r_shadow <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_cutoff <= cfg_cutoff;
                        r_max    <= cfg_max;
                        r_start  <= cfg_start;
                        r_run    <= run_cycles;
                        err_idx  <= 1'b0;
                        busy     <= 1'b1;
                        wready   <= 1'b1;
                        wr_addr  <= `CTR_CUTOFF_ADDR;
                        wdata    <= cfg_cutoff;
                        r_state  <= S_W_CUT;
                    end
                end
                S_W_CUT: begin
                    wr_addr <= `CTR_MAX_ADDR;
                    wdata   <= r_max;
                    r_state <= S_W_MAX;
                end
                S_W_MAX: begin
                    wready  <= 1'b0;
                    e_ready <= 1'b1;
                    r_state <= S_EDGE;
                end
                S_EDGE: begin
                    if (e_valid) begin
                        if (w_idx_bad) begin
                            // Dropped edge: stays in EDGE unless it was the last.
                            err_idx <= 1'b1;
                            if (e_last) begin
                                e_ready <= 1'b0;
                                wready  <= 1'b1;
                                wr_addr <= `START_ADDR;
                                wdata   <= r_start;
                                r_state <= S_W_START;
                            end
                        end else begin
                            r_i     <= e_i;
                            r_j     <= e_j;
                            r_w     <= e_w;
                            r_last  <= e_last;
                            e_ready <= 1'b0;
                            wready  <= 1'b1;
                            wr_addr <= weight_addr(e_i, e_j);
                            wdata   <= e_w;
                            r_state <= S_W_IJ;
                        end
                    end
                end
                S_W_IJ: begin
                    if (r_i != r_j) begin
                        wr_addr <= weight_addr(r_j, r_i);
                        wdata   <= r_w;
                        r_state <= S_W_JI;
                    end else if (r_last) begin
                        wr_addr <= `START_ADDR;
                        wdata   <= r_start;
                        r_state <= S_W_START;
                    end else begin
                        wready  <= 1'b0;
                        e_ready <= 1'b1;
                        r_state <= S_EDGE;
                    end
                end
                S_W_JI: begin
                    if (r_last) begin
                        wr_addr <= `START_ADDR;
                        wdata   <= r_start;
                        r_state <= S_W_START;
                    end else begin
                        wready  <= 1'b0;
                        e_ready <= 1'b1;
                        r_state <= S_EDGE;
                    end
                end
                S_W_START: begin
                    wready <= 1'b0;
                    if (r_run == '0) begin
                        araddr  <= phase_addr('0);
                        r_k     <= '0;
                        r_lat   <= c_lat_w'(1);
                        r_state <= S_RD;
                    end else begin
                        r_cnt   <= r_run;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        araddr  <= phase_addr('0);
                        r_k     <= '0;
                        r_lat   <= c_lat_w'(1);
                        r_state <= S_RD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RD: begin
                    // r_lat counts edges since araddr changed; rdata is
                    // sampled on the READ_LAT-th one.
                    if (r_lat == c_lat) begin
                        if (r_k == c_k_last) begin
                            spins   <= w_shadow_next;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_shadow <= w_shadow_next;
                            r_k      <= w_k_next;
                            araddr   <= phase_addr(w_k_next);
                            r_lat    <= c_lat_w'(1);
                        end
                    end else begin
                        r_lat <= r_lat + c_lat_w'(1);
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    e_ready <= 1'b0;
                    wready  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ising_prog_seq.sv
// ============================================================================
//  Module   : tb_ising_prog_seq
//  Purpose  : Self-checking bench for ising_prog_seq (N=8, READ_LAT=2,
//             IDX_W=4 so out-of-range indices can be driven). A write-order
//             model and a phase memory model are checked every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ising_prog_seq;

    localparam int          N        = 8;
    localparam int          READ_LAT = 2;
    localparam int          IDX_W    = 4;
    localparam logic [31:0] C_START  = 32'h0000_0000;
    localparam logic [31:0] C_CUT    = 32'h0000_0004;
    localparam logic [31:0] C_MAX    = 32'h0000_0008;
    localparam logic [31:0] C_PBASE  = 32'h0001_0000;
    localparam logic [31:0] C_WBASE  = 32'h0100_0000;

    logic             clk = 1'b0;
    logic             axi_rstn;
    logic             go;
    logic [31:0]      cfg_cutoff, cfg_max, cfg_start;
    logic [31:0]      run_cycles;
    logic             e_valid;
    logic             e_ready;
    logic [IDX_W-1:0] e_i, e_j;
    logic [31:0]      e_w;
    logic             e_last;
    logic             wready;
    logic [31:0]      wr_addr, wdata, araddr;
    logic [31:0]      rdata = 32'h0;
    logic             busy, done, err_idx;
    logic [N-1:0]     spins;

    ising_prog_seq #(.N(N), .READ_LAT(READ_LAT), .CNT_W(32), .IDX_W(IDX_W)) dut (
        .clk(clk), .axi_rstn(axi_rstn), .go(go),
        .cfg_cutoff(cfg_cutoff), .cfg_max(cfg_max), .cfg_start(cfg_start),
        .run_cycles(run_cycles),
        .e_valid(e_valid), .e_ready(e_ready), .e_i(e_i), .e_j(e_j),
        .e_w(e_w), .e_last(e_last),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .araddr(araddr), .rdata(rdata),
        .busy(busy), .done(done), .spins(spins), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int           nvec = 0;
    int           nerr = 0;
    int           n_done = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  cap_q[$];
    logic [31:0]  phase_mem [N];
    logic [N-1:0] exp_spins = '0;
    logic         exp_armed = 1'b0;
    logic [31:0]  cur_start = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase memory: one register stage, so data appears one edge after araddr.
    function automatic logic [31:0] phase_lookup(input logic [31:0] a);
        logic [31:0] off;
        off = a - C_PBASE;
        if (a >= C_PBASE && off < 32'(N * 4) && off[1:0] == 2'b00)
            return phase_mem[int'(off >> 2)];
        return 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk) rdata <= phase_lookup(araddr);

    // Compare process: every write must match the model's next expected
    // write, and every done pulse must carry the model's spin vector.
    always @(negedge clk) begin
        logic [63:0] e;
        if (axi_rstn) begin
            if (wready) begin
                cap_q.push_back({wr_addr, wdata});
                chk("eready_during_write", 64'(e_ready), 64'd0);
                chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e[63:32]));
                    chk("wdata", 64'(wdata), 64'(e[31:0]));
                end
            end
            if (done) begin
                n_done++;
                chk("done_armed", 64'(exp_armed), 64'd1);
                chk("spins", 64'(spins), 64'(exp_spins));
                exp_armed = 1'b0;
            end
        end
    end

    task automatic set_phases(input logic [31:0] p0, p1, p2, p3, p4, p5, p6, p7);
        phase_mem[0] = p0; phase_mem[1] = p1; phase_mem[2] = p2; phase_mem[3] = p3;
        phase_mem[4] = p4; phase_mem[5] = p5; phase_mem[6] = p6; phase_mem[7] = p7;
    endtask

    // Called at a negedge; returns at the negedge after go was sampled.
    task automatic start_prog(input logic [31:0] cut, mx, st, run);
        cap_q.delete();
        exp_q.delete();
        n_done = 0;
        exp_q.push_back({C_CUT, cut});
        exp_q.push_back({C_MAX, mx});
        for (int k = 0; k < N; k++) exp_spins[k] = (phase_mem[k] >= cut);
        exp_armed  = 1'b1;
        cur_start  = st;
        cfg_cutoff = cut; cfg_max = mx; cfg_start = st; run_cycles = run;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic send_edge(input int i, input int j, input logic [31:0] w, input logic last);
        int n;
        if (i < N && j < N) begin
            exp_q.push_back({C_WBASE + 32'(i * 4) + 32'(j * 8192), w});
            if (i != j) exp_q.push_back({C_WBASE + 32'(j * 4) + 32'(i * 8192), w});
        end
        if (last) exp_q.push_back({C_START, cur_start});
        e_i = IDX_W'(i); e_j = IDX_W'(j); e_w = w; e_last = last; e_valid = 1'b1;
        n = 0;
        while (!e_ready && n < 50) begin @(negedge clk); n++; end
        chk("edge_accepted", 64'(e_ready), 64'd1);
        @(negedge clk);
        e_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin @(negedge clk); n++; end
        chk("done_seen", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        chk("one_done", 64'(n_done), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_start_write(input int limit);
        int n;
        n = 0;
        while (!(wready && wr_addr == C_START) && n < limit) begin @(negedge clk); n++; end
        chk("start_write_seen", 64'(wready && wr_addr == C_START), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        axi_rstn = 1'b0; go = 1'b0;
        cfg_cutoff = '0; cfg_max = '0; cfg_start = '0; run_cycles = '0;
        e_valid = 1'b0; e_i = '0; e_j = '0; e_w = '0; e_last = 1'b0;
        set_phases(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_e_ready", 64'(e_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err_idx", 64'(err_idx), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_spins", 64'(spins), 64'd0);
        axi_rstn = 1'b1;
        @(negedge clk);

        // Basic off-diagonal edge plus readback of the reference phases
        set_phases(6, 2, 5, 7, 1, 0, 0, 6);
        start_prog(4, 8, 32'h10, 3);
        chk("busy_after_go", 64'(busy), 64'd1);
        send_edge(0, 1, 0, 1'b1);
        wait_done(200);
        chk("t1_nwrites", 64'(cap_q.size()), 64'd5);
        chk("t1_w0", cap_q[0], {C_CUT, 32'd4});
        chk("t1_w1", cap_q[1], {C_MAX, 32'd8});
        chk("t1_w2", cap_q[2], {C_WBASE + 32'h2000, 32'd0});
        chk("t1_w3", cap_q[3], {C_WBASE + 32'h4, 32'd0});
        chk("t1_w4", cap_q[4], {C_START, 32'h10});
        chk("t1_spins_lit", 64'(spins), 64'h8D);

        // Diagonal edge: a single weight write
        set_phases(9, 9, 0, 0, 9, 0, 9, 0);
        start_prog(5, 9, 1, 2);
        send_edge(1, 1, 1, 1'b1);
        wait_done(200);
        chk("t2_nwrites", 64'(cap_q.size()), 64'd4);
        chk("t2_diag", cap_q[2], {C_WBASE + 32'h2004, 32'd1});

        // Out-of-range edge is dropped and flagged
        start_prog(4, 8, 0, 1);
        send_edge(9, 0, 2, 1'b0);
        send_edge(2, 3, 2, 1'b1);
        wait_done(200);
        chk("t3_err_idx", 64'(err_idx), 64'd1);
        chk("t3_nwrites", 64'(cap_q.size()), 64'd5);

        // run_cycles=0: read starts right after START; go while busy ignored
        set_phases(1, 5, 2, 8, 0, 3, 3, 9);
        start_prog(3, 7, 2, 0);
        chk("t4_err_cleared", 64'(err_idx), 64'd0);
        send_edge(2, 5, 4, 1'b1);
        wait_start_write(100);
        @(negedge clk);
        lat = 1;
        chk("t4_first_araddr", 64'(araddr), 64'(C_PBASE));
        while (!done && lat < 100) begin
            if (lat == 4) begin go = 1'b1; cfg_cutoff = 0; cfg_start = 32'h77; end
            if (lat == 5) go = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("t4_done_latency", 64'(lat), 64'd17);
        wait_done(5);

        // Reset in the middle of RUN
        start_prog(4, 8, 1, 500);
        send_edge(3, 4, 2, 1'b1);
        wait_start_write(100);
        repeat (5) @(negedge clk);
        axi_rstn = 1'b0;
        @(negedge clk);
        exp_armed = 1'b0;
        chk("t5_busy_in_rst", 64'(busy), 64'd0);
        chk("t5_wready_in_rst", 64'(wready), 64'd0);
        axi_rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_done", 64'(n_done), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // Clean multi-edge sequence after the reset
        set_phases(0, 3, 9, 2, 3, 1, 4, 100);
        start_prog(3, 8, 7, 2);
        send_edge(0, 1, 2, 1'b0);
        send_edge(2, 2, 1, 1'b0);
        send_edge(7, 3, 0, 1'b0);
        send_edge(5, 6, 2, 1'b1);
        wait_done(300);
        chk("t6_nwrites", 64'(cap_q.size()), 64'd10);
        chk("t6_spins_lit", 64'(spins), 64'hD6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
